// File: rtl/usb_rx_phy.sv
// Low-speed USB receive front end: pin synchronisers, bit-clock recovery, NRZI decode,
// bit unstuffing and LSB-first byte assembly for the SIE receive side, plus bus-reset detect.
module usb_rx_phy #(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned RESET_CYCLES = 240
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       d_p,
    input  logic       d_n,
    input  logic       tx_active,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_active,
    output logic       rx_error,
    output logic       usb_reset
);

    localparam int unsigned PH_W  = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int unsigned CNT_W = $clog2(RESET_CYCLES + 1);

    localparam logic [PH_W-1:0]  PH_ZERO   = {PH_W{1'b0}};
    localparam logic [PH_W-1:0]  PH_ONE    = PH_W'(1);
    localparam logic [PH_W-1:0]  PH_SAMPLE = PH_W'(CLKS_PER_BIT / 2);
    localparam logic [PH_W-1:0]  PH_LAST   = PH_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] SE0_MAX   = CNT_W'(RESET_CYCLES);

    localparam logic [1:0] LS_SE0 = 2'b00;
    localparam logic [1:0] LS_J   = 2'b01;
    localparam logic [1:0] LS_K   = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_SYNC      = 3'd1,
        ST_DATA      = 3'd2,
        ST_EOP       = 3'd3,
        ST_WAIT_IDLE = 3'd4
    } state_t;

    // SE1 is not a legal bus state; it is folded into SE0 so it ends packets.
    function automatic logic [1:0] line_decode(input logic dp, input logic dn);
        logic [1:0] ls;
        case ({dp, dn})
            2'b01:   ls = LS_J;
            2'b10:   ls = LS_K;
            default: ls = LS_SE0;
        endcase
        return ls;
    endfunction

    logic             dp_meta_q, dp_sync_q, dn_meta_q, dn_sync_q;
    logic [1:0]       line_s;
    logic [1:0]       line_prev_q;
    logic             chg_s;
    logic [PH_W-1:0]  phase_q, phase_d;
    logic             smp_en_s;
    logic             bit_s;
    logic [CNT_W-1:0] se0_cnt_q, se0_cnt_d;
    logic             usb_reset_q, usb_reset_d;

    state_t           state_q;
    logic [2:0]       zero_cnt_q;
    logic [2:0]       ones_cnt_q;
    logic [2:0]       bit_cnt_q;
    logic [7:0]       shift_q;
    logic [1:0]       prev_smp_q;
    logic [2:0]       j_cnt_q;
    logic             se0_seen_q;
    logic [7:0]       rx_data_q;
    logic             rx_valid_q;
    logic             rx_active_q;
    logic             rx_error_q;

    // Two-flop synchronisers, line-state history, phase counter and SE0 counter.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dp_meta_q   <= 1'b0;
            dp_sync_q   <= 1'b0;
            dn_meta_q   <= 1'b1;
            dn_sync_q   <= 1'b1;
            line_prev_q <= LS_J;
            phase_q     <= PH_ZERO;
            se0_cnt_q   <= CNT_ZERO;
            usb_reset_q <= 1'b0;
        end else begin
            dp_meta_q   <= d_p;
            dp_sync_q   <= dp_meta_q;
            dn_meta_q   <= d_n;
            dn_sync_q   <= dn_meta_q;
            line_prev_q <= line_s;
            phase_q     <= phase_d;
            se0_cnt_q   <= se0_cnt_d;
            usb_reset_q <= usb_reset_d;
        end
    end

    // Line decode, bit-clock recovery, NRZI bit and bus-reset counter next state.
    always_comb begin
        line_s = line_decode(dp_sync_q, dn_sync_q);
        chg_s  = (line_s != line_prev_q);

        if (tx_active) begin
            phase_d = PH_ZERO;
        end else if (chg_s || (phase_q == PH_LAST)) begin
            phase_d = PH_ZERO;
        end else begin
            phase_d = phase_q + PH_ONE;
        end

        // A sample coinciding with an edge would be taken again after the re-phase, so skip it.
        smp_en_s = (phase_q == PH_SAMPLE) && !chg_s && !tx_active;
        bit_s    = (line_s == prev_smp_q);

        if (line_s != LS_SE0) begin
            se0_cnt_d = CNT_ZERO;
        end else if (se0_cnt_q == SE0_MAX) begin
            se0_cnt_d = SE0_MAX;
        end else begin
            se0_cnt_d = se0_cnt_q + CNT_ONE;
        end
        usb_reset_d = (se0_cnt_d == SE0_MAX);
    end

    // Receive FSM: SYNC detection, unstuffing, byte assembly and EOP handling.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            zero_cnt_q  <= 3'd0;
            ones_cnt_q  <= 3'd0;
            bit_cnt_q   <= 3'd0;
            shift_q     <= 8'h00;
            prev_smp_q  <= LS_J;
            j_cnt_q     <= 3'd0;
            se0_seen_q  <= 1'b0;
            rx_data_q   <= 8'h00;
            rx_valid_q  <= 1'b0;
            rx_active_q <= 1'b0;
            rx_error_q  <= 1'b0;
        end else begin
            rx_valid_q <= 1'b0;
            rx_error_q <= 1'b0;
            if (tx_active) begin
                state_q     <= ST_IDLE;
                rx_active_q <= 1'b0;
                prev_smp_q  <= LS_J;
            end else if (usb_reset_q) begin
                state_q     <= ST_IDLE;
                rx_active_q <= 1'b0;
            end else if (smp_en_s) begin
                prev_smp_q <= line_s;
                case (state_q)
                    ST_IDLE: begin
                        if (line_s == LS_K) begin
                            state_q    <= ST_SYNC;
                            zero_cnt_q <= 3'd1;
                        end else begin
                            state_q <= ST_IDLE;
                        end
                    end
                    ST_SYNC: begin
                        if (line_s == LS_SE0) begin
                            state_q <= ST_IDLE;
                        end else if (!bit_s) begin
                            if (zero_cnt_q != 3'd7) begin
                                zero_cnt_q <= zero_cnt_q + 3'd1;
                            end else begin
                                zero_cnt_q <= zero_cnt_q;
                            end
                        end else if (zero_cnt_q >= 3'd3) begin
                            state_q     <= ST_DATA;
                            rx_active_q <= 1'b1;
                            bit_cnt_q   <= 3'd0;
                            ones_cnt_q  <= 3'd0;
                        end else begin
                            state_q <= ST_IDLE;
                        end
                    end
                    ST_DATA: begin
                        if (line_s == LS_SE0) begin
                            state_q    <= ST_EOP;
                            rx_error_q <= (bit_cnt_q != 3'd0);
                            bit_cnt_q  <= 3'd0;
                        end else if (ones_cnt_q == 3'd6) begin
                            ones_cnt_q <= 3'd0;
                            if (bit_s) begin
                                rx_error_q  <= 1'b1;
                                rx_active_q <= 1'b0;
                                state_q     <= ST_WAIT_IDLE;
                                j_cnt_q     <= 3'd0;
                                se0_seen_q  <= 1'b0;
                            end else begin
                                state_q <= ST_DATA;
                            end
                        end else begin
                            shift_q    <= {bit_s, shift_q[7:1]};
                            ones_cnt_q <= bit_s ? (ones_cnt_q + 3'd1) : 3'd0;
                            if (bit_cnt_q == 3'd7) begin
                                rx_data_q  <= {bit_s, shift_q[7:1]};
                                rx_valid_q <= 1'b1;
                                bit_cnt_q  <= 3'd0;
                            end else begin
                                bit_cnt_q <= bit_cnt_q + 3'd1;
                            end
                        end
                    end
                    ST_EOP: begin
                        if (line_s == LS_J) begin
                            rx_active_q <= 1'b0;
                            state_q     <= ST_IDLE;
                        end else if (line_s == LS_K) begin
                            rx_error_q  <= 1'b1;
                            rx_active_q <= 1'b0;
                            state_q     <= ST_WAIT_IDLE;
                            j_cnt_q     <= 3'd0;
                            se0_seen_q  <= 1'b0;
                        end else begin
                            state_q <= ST_EOP;
                        end
                    end
                    ST_WAIT_IDLE: begin
                        if (line_s == LS_J) begin
                            if (se0_seen_q || (j_cnt_q == 3'd7)) begin
                                state_q <= ST_IDLE;
                            end else begin
                                j_cnt_q <= j_cnt_q + 3'd1;
                            end
                        end else if (line_s == LS_SE0) begin
                            se0_seen_q <= 1'b1;
                            j_cnt_q    <= 3'd0;
                        end else begin
                            se0_seen_q <= 1'b0;
                            j_cnt_q    <= 3'd0;
                        end
                    end
                    default: begin
                        state_q     <= ST_IDLE;
                        rx_active_q <= 1'b0;
                    end
                endcase
            end else begin
                state_q <= state_q;
            end
        end
    end

    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign rx_active = rx_active_q;
    assign rx_error  = rx_error_q;
    assign usb_reset = usb_reset_q;

endmodule

// File: tb/tb_usb_rx_phy.sv
// Scoreboard bench for usb_rx_phy: an NRZI/bit-stuffing line driver pushes expected bytes,
// a negedge monitor pops and compares them; scenario tasks check framing, errors and resets.
module tb_usb_rx_phy;

    localparam int CPB     = 16;
    localparam int RST_CYC = 240;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       d_p;
    logic       d_n;
    logic       tx_active;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_active;
    logic       rx_error;
    logic       usb_reset;

    int         total   = 0;
    int         bad     = 0;
    int         err_cnt = 0;
    logic [7:0] exp_q[$];
    logic [7:0] exp_b;
    logic       lvl_k;
    int         ones;
    bit         jitter = 1'b0;
    bit         jflip  = 1'b0;

    usb_rx_phy #(.CLKS_PER_BIT(CPB), .RESET_CYCLES(RST_CYC)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .d_p       (d_p),
        .d_n       (d_n),
        .tx_active (tx_active),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_active (rx_active),
        .rx_error  (rx_error),
        .usb_reset (usb_reset)
    );

    always #5 clk = ~clk;

    initial begin
        #900000;
        $display("FAIL watchdog expired got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    // Byte scoreboard and error-pulse counter.
    always @(negedge clk) begin
        if (rx_error === 1'b1) err_cnt++;
        if (rx_valid === 1'b1) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_byte got=%02h want=none", rx_data);
            end else begin
                exp_b = exp_q.pop_front();
                if (rx_data !== exp_b) begin
                    bad++;
                    $display("FAIL rx_data got=%02h want=%02h", rx_data, exp_b);
                end
            end
            total++;
            if (rx_active !== 1'b1) begin
                bad++;
                $display("FAIL valid_while_inactive got=%b want=1", rx_active);
            end
        end
    end

    task automatic drive_line(input logic [1:0] ls, input int n);
        {d_p, d_n} = ls;
        repeat (n) @(negedge clk);
    endtask

    task automatic next_len(output int n);
        if (jitter) begin
            jflip = ~jflip;
            n = jflip ? 15 : 17;
        end else begin
            n = CPB;
        end
    endtask

    task automatic send_bit(input logic b);
        int n;
        if (!b) lvl_k = ~lvl_k;
        next_len(n);
        drive_line(lvl_k ? 2'b10 : 2'b01, n);
    endtask

    task automatic send_stuffed(input logic b);
        send_bit(b);
        if (b) begin
            ones++;
            if (ones == 6) begin
                send_bit(1'b0);
                ones = 0;
            end
        end else begin
            ones = 0;
        end
    endtask

    task automatic send_byte(input logic [7:0] v, input bit expect_it);
        if (expect_it) exp_q.push_back(v);
        for (int i = 0; i < 8; i++) send_stuffed(v[i]);
    endtask

    task automatic send_sync();
        lvl_k = 1'b0;
        for (int i = 0; i < 7; i++) send_bit(1'b0);
        send_bit(1'b1);
        ones = 0;
    endtask

    task automatic send_se0();
        int n;
        for (int i = 0; i < 2; i++) begin
            next_len(n);
            drive_line(2'b00, n);
        end
    endtask

    task automatic send_j(input int bits);
        int n;
        lvl_k = 1'b0;
        for (int i = 0; i < bits; i++) begin
            next_len(n);
            drive_line(2'b01, n);
        end
    endtask

    task automatic test_reset();
        total++; if (rx_data !== 8'h00)  begin bad++; $display("FAIL reset_rx_data got=%02h want=00", rx_data); end
        total++; if (rx_valid !== 1'b0)  begin bad++; $display("FAIL reset_rx_valid got=%b want=0", rx_valid); end
        total++; if (rx_active !== 1'b0) begin bad++; $display("FAIL reset_rx_active got=%b want=0", rx_active); end
        total++; if (rx_error !== 1'b0)  begin bad++; $display("FAIL reset_rx_error got=%b want=0", rx_error); end
        total++; if (usb_reset !== 1'b0) begin bad++; $display("FAIL reset_usb_reset got=%b want=0", usb_reset); end
    endtask

    task automatic test_single_byte();
        int e0 = err_cnt;
        send_sync();
        send_byte(8'hC3, 1'b1);
        total++; if (rx_active !== 1'b1) begin bad++; $display("FAIL single_active got=%b want=1", rx_active); end
        send_se0();
        total++; if (rx_active !== 1'b1) begin bad++; $display("FAIL single_active_se0 got=%b want=1", rx_active); end
        send_j(1);
        total++; if (rx_active !== 1'b0) begin bad++; $display("FAIL single_active_after_j got=%b want=0", rx_active); end
        total++; if (rx_data !== 8'hC3) begin bad++; $display("FAIL single_data_hold got=%02h want=c3", rx_data); end
        send_j(2);
        total++; if (exp_q.size() != 0) begin bad++; $display("FAIL single_missing got=%0d want=0", exp_q.size()); exp_q.delete(); end
        total++; if (err_cnt - e0 != 0) begin bad++; $display("FAIL single_errors got=%0d want=0", err_cnt - e0); end
    endtask

    task automatic test_stuffed();
        int e0 = err_cnt;
        send_sync();
        send_byte(8'hFF, 1'b1);
        send_byte(8'hFF, 1'b1);
        send_se0();
        send_j(3);
        total++; if (exp_q.size() != 0) begin bad++; $display("FAIL stuffed_missing got=%0d want=0", exp_q.size()); exp_q.delete(); end
        total++; if (err_cnt - e0 != 0) begin bad++; $display("FAIL stuffed_errors got=%0d want=0", err_cnt - e0); end
    endtask

    task automatic test_stuff_error();
        int e0 = err_cnt;
        send_sync();
        for (int i = 0; i < 7; i++) send_bit(1'b1);
        total++; if (rx_active !== 1'b0) begin bad++; $display("FAIL stufferr_active got=%b want=0", rx_active); end
        total++; if (err_cnt - e0 != 1) begin bad++; $display("FAIL stufferr_pulse got=%0d want=1", err_cnt - e0); end
        for (int i = 0; i < 12; i++) send_bit(i[0]);
        send_se0();
        send_j(3);
        total++; if (err_cnt - e0 != 1) begin bad++; $display("FAIL stufferr_total got=%0d want=1", err_cnt - e0); end
        total++; if (rx_active !== 1'b0) begin bad++; $display("FAIL stufferr_active_end got=%b want=0", rx_active); end
        total++; if (exp_q.size() != 0) begin bad++; $display("FAIL stufferr_queue got=%0d want=0", exp_q.size()); exp_q.delete(); end
    endtask

    task automatic test_short_eop();
        int e0 = err_cnt;
        send_sync();
        send_byte(8'h3C, 1'b1);
        send_stuffed(1'b1);
        send_stuffed(1'b0);
        send_stuffed(1'b1);
        send_stuffed(1'b0);
        send_se0();
        total++; if (err_cnt - e0 != 1) begin bad++; $display("FAIL short_error got=%0d want=1", err_cnt - e0); end
        total++; if (rx_active !== 1'b1) begin bad++; $display("FAIL short_active_se0 got=%b want=1", rx_active); end
        send_j(1);
        total++; if (rx_active !== 1'b0) begin bad++; $display("FAIL short_active_j got=%b want=0", rx_active); end
        send_j(2);
        total++; if (exp_q.size() != 0) begin bad++; $display("FAIL short_missing got=%0d want=0", exp_q.size()); exp_q.delete(); end
    endtask

    task automatic test_jitter();
        int e0 = err_cnt;
        jitter = 1'b1;
        send_sync();
        send_byte(8'h5A, 1'b1);
        send_byte(8'hA5, 1'b1);
        send_se0();
        send_j(3);
        jitter = 1'b0;
        total++; if (exp_q.size() != 0) begin bad++; $display("FAIL jitter_missing got=%0d want=0", exp_q.size()); exp_q.delete(); end
        total++; if (err_cnt - e0 != 0) begin bad++; $display("FAIL jitter_errors got=%0d want=0", err_cnt - e0); end
    endtask

    task automatic test_back_to_back();
        int e0 = err_cnt;
        send_sync();
        send_byte(8'h01, 1'b1);
        send_se0();
        send_j(1);
        send_sync();
        send_byte(8'h80, 1'b1);
        send_byte(8'h7E, 1'b1);
        send_byte(8'hFC, 1'b1);
        send_byte(8'h00, 1'b1);
        send_se0();
        send_j(3);
        total++; if (exp_q.size() != 0) begin bad++; $display("FAIL b2b_missing got=%0d want=0", exp_q.size()); exp_q.delete(); end
        total++; if (err_cnt - e0 != 0) begin bad++; $display("FAIL b2b_errors got=%0d want=0", err_cnt - e0); end
        total++; if (rx_data !== 8'h00) begin bad++; $display("FAIL b2b_last_data got=%02h want=00", rx_data); end
    endtask

    task automatic test_tx_abort();
        int e0 = err_cnt;
        send_sync();
        for (int i = 0; i < 4; i++) send_stuffed(1'b1);
        total++; if (rx_active !== 1'b1) begin bad++; $display("FAIL tx_active_before got=%b want=1", rx_active); end
        tx_active = 1'b1;
        for (int i = 0; i < 2; i++) send_stuffed(1'b1);
        total++; if (rx_active !== 1'b0) begin bad++; $display("FAIL tx_active_during got=%b want=0", rx_active); end
        tx_active = 1'b0;
        send_se0();
        send_j(3);
        total++; if (rx_active !== 1'b0) begin bad++; $display("FAIL tx_active_after got=%b want=0", rx_active); end
        total++; if (err_cnt - e0 != 0) begin bad++; $display("FAIL tx_errors got=%0d want=0", err_cnt - e0); end
    endtask

    task automatic test_bus_reset();
        int n = 0;
        int m = 0;
        {d_p, d_n} = 2'b00;
        while (usb_reset !== 1'b1 && n < 400) begin
            @(negedge clk);
            n++;
        end
        total++; if (n < RST_CYC || n > RST_CYC + 4) begin bad++; $display("FAIL usb_reset_rise got=%0d want=%0d..%0d", n, RST_CYC, RST_CYC + 4); end
        while (n < 300) begin
            @(negedge clk);
            n++;
        end
        total++; if (usb_reset !== 1'b1) begin bad++; $display("FAIL usb_reset_hold got=%b want=1", usb_reset); end
        total++; if (rx_active !== 1'b0) begin bad++; $display("FAIL usb_reset_active got=%b want=0", rx_active); end
        {d_p, d_n} = 2'b01;
        while (usb_reset !== 1'b0 && m < 20) begin
            @(negedge clk);
            m++;
        end
        total++; if (m < 2 || m > 4) begin bad++; $display("FAIL usb_reset_fall got=%0d want=2..4", m); end
        send_j(2);
        send_sync();
        send_byte(8'h96, 1'b1);
        send_se0();
        send_j(3);
        total++; if (exp_q.size() != 0) begin bad++; $display("FAIL post_reset_missing got=%0d want=0", exp_q.size()); exp_q.delete(); end
    endtask

    initial begin
        reset_n   = 1'b0;
        d_p       = 1'b0;
        d_n       = 1'b1;
        tx_active = 1'b0;
        lvl_k     = 1'b0;
        ones      = 0;
        repeat (4) @(negedge clk);
        test_reset();
        reset_n = 1'b1;
        send_j(3);
        test_single_byte();
        test_stuffed();
        test_stuff_error();
        test_short_eop();
        test_jitter();
        test_back_to_back();
        test_tx_abort();
        test_bus_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
